// File: rtl/phase_counter_pkg.sv
// Shared state encoding and phase codes for the phase_counter loop sequencer.
package phase_counter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int PH_W = 3;

    localparam logic [PH_W-1:0] PH_IDLE   = 3'd0;
    localparam logic [PH_W-1:0] PH_FIRST  = 3'd1;
    localparam logic [PH_W-1:0] PH_SECOND = 3'd2;
    localparam logic [PH_W-1:0] PH_BODY   = 3'd3;
    localparam logic [PH_W-1:0] PH_LAST   = 3'd4;

endpackage

// File: rtl/phase_counter_decode.sv
// phase_decode: combinational phase tagging of the current loop index.
module phase_decode
    import phase_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  state_t           state,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] limit_q,
    output logic [PH_W-1:0]  phase
);

    // LAST outranks FIRST/SECOND so single- and two-iteration loops still flag their exit.
    always_comb begin
        phase = PH_IDLE;
        if (state != RUN)
            phase = PH_IDLE;
        else if (cnt == limit_q)
            phase = PH_LAST;
        else if (cnt == '0)
            phase = PH_FIRST;
        else if (cnt == WIDTH'(1))
            phase = PH_SECOND;
        else
            phase = PH_BODY;
    end

endmodule

// File: rtl/phase_counter.sv
// Loop sequencer counting 0..limit with phase tags and a done pulse.
// Define PHASE_COUNTER_WRAP_EN for free-running mode (wrap at limit, exit on start).
module phase_counter
    import phase_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cnt,
    output logic [PH_W-1:0]  phase_comb,
    output logic [PH_W-1:0]  phase_reg
);

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] limit_q, limit_next;
`ifdef PHASE_COUNTER_WRAP_EN
    logic             wrap, wrap_next;
    logic             exit_q, exit_next;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            limit_q   <= '0;
            phase_reg <= PH_IDLE;
`ifdef PHASE_COUNTER_WRAP_EN
            wrap      <= 1'b0;
            exit_q    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            limit_q   <= limit_next;
            phase_reg <= phase_comb;
`ifdef PHASE_COUNTER_WRAP_EN
            wrap      <= wrap_next;
            exit_q    <= exit_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        limit_next = limit_q;
`ifdef PHASE_COUNTER_WRAP_EN
        wrap_next  = 1'b0;
        exit_next  = exit_q;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
`ifdef PHASE_COUNTER_WRAP_EN
                exit_next = 1'b0;
`endif
                if (start) begin
                    state_next = RUN;
                    limit_next = limit;
                end
            end
            RUN: begin
`ifdef PHASE_COUNTER_WRAP_EN
                // An exit request raised during a stall is remembered until the iteration completes.
                if (stall)
                    exit_next = exit_q | start;
                else if (start || exit_q)
                    state_next = DONE;
                else if (cnt == limit_q) begin
                    cnt_next  = '0;
                    wrap_next = 1'b1;
                end else
                    cnt_next = cnt + 1'b1;
`else
                if (!stall) begin
                    if (cnt == limit_q)
                        state_next = DONE;
                    else
                        cnt_next = cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
`ifdef PHASE_COUNTER_WRAP_EN
        done = (state == DONE) || wrap;
`else
        done = (state == DONE);
`endif
    end

    phase_decode #(.WIDTH(WIDTH)) u_decode (
        .state   (state),
        .cnt     (cnt),
        .limit_q (limit_q),
        .phase   (phase_comb)
    );

endmodule
